xif_copro_id_stage: RTL
=======================

Name: xif_copro_id_stage

Overview:
- Issue/decode stage directly upstream of the coprocessor execution stage.
- Accepts CV-X-IF issue requests and decodes custom-0 instructions into xif_copro_pkg::copro_op_e.
- Buffers accepted instructions until commit and drops killed ones.
- Hands committed instructions to the execution stage over a valid/ready handshake, with operands and a tag (id, rd).

Parameters:
- XLEN, 64, operand width.
- IdWidth, 4, width of XIF instruction id.
- Depth, 2, entries in the pending-commit queue (power of two, ≥2).
- tag_t, logic, downstream tag type; struct {id, rd} from the package.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  issue request consumed this cycle.
- issue_instr_i  in  32  instruction word.
- issue_id_i  in  IdWidth  instruction id.
- issue_rs1_i  in  XLEN  rs1 value.
- issue_rs2_i  in  XLEN  rs2 value.
- issue_rs_valid_i  in  2  rs1/rs2 valid.
- issue_accept_o  out  1  instruction is ours; valid when issue_valid_i & issue_ready_o.
- issue_writeback_o  out  1  instruction writes rd; equals issue_accept_o.
- commit_valid_i  in  1  commit valid.
- commit_id_i  in  IdWidth  committed id.
- commit_kill_i  in  1  kill the instruction.
- operand_a_o  out  XLEN  to EX.
- operand_b_o  out  XLEN  to EX.
- operator_o  out  copro_op_e  to EX.
- tag_o  out  tag_t  {id, rd} to EX.
- out_valid_o  out  1  EX request valid.
- out_ready_i  in  1  EX ready.

Behaviour:
- Decode: opcode 7'h0B, funct7 0.
  - funct3 0 → BITREV (needs rs1).
  - funct3 1 → ROTLEFT (needs rs1, rs2).
  - funct3 2 → ROTRIGHT (needs rs1, rs2).
  - Anything else → not accepted, operator NONE.
- issue_ready_o:
  - Non-accepted instruction: 1 (rejected in one cycle, nothing enqueued).
  - Accepted instruction: 1 only when queue not full AND all required rs_valid bits set.
  - Combinational.
- Enqueue on issue_valid_i & issue_ready_o & accept. Entry holds operator, rs1, rs2 (rs2 zeroed for BITREV), id, rd, committed=0, killed=0.
- Commit: commit_valid_i matches the oldest valid, uncommitted entry with equal id; sets committed, and killed if commit_kill_i. A commit matching no entry is ignored.
- Issue and commit in the same cycle with equal id: the entry is enqueued with committed/killed already set.
- Dequeue, head only, in order:
  - killed head: dropped in 1 cycle, no out_valid_o.
  - committed, unkilled head: out_valid_o=1.
  - Pop on out_valid_o & out_ready_i.
  - Uncommitted head: blocks.
- Outputs are driven from the head entry. While out_valid_o=1 without ready, all outputs hold stable.
- Minimum latency (macro off): issue+commit in cycle N → out_valid_o in cycle N+1.
- Full queue: issue_ready_o=0 for accepted instructions even if a pop happens that cycle (no shortcut).
- Pointers wrap modulo Depth. The count distinguishes full from empty.
- Reset (also mid-operation): queue emptied, out_valid_o=0, operand/tag outputs 0, operator_o=NONE. Any entries in flight are lost without handshake.

Optional Feature:
- XIF_COPRO_ID_BYPASS_EN defined:
  - Applies when the queue is empty and the enqueue is committed-unkilled in its issue cycle.
  - out_valid_o asserts combinationally in that same cycle with the issue data (0-cycle latency).
  - If out_ready_i=1 the entry is never written to the queue.
- Not defined: no bypass, latency ≥1 as above.

Decomposition:
- xif_copro_pkg gets:
  - OPCODE_CUSTOM0.
  - FUNCT3_BITREV/ROTLEFT/ROTRIGHT constants.
  - copro_tag_t struct {id, rd}.
  - Pending-entry struct type.
  - Reuse copro_op_e.
- Sub-module: xif_copro_decoder (combinational). Maps instr → accept, operator, rs-required mask, rd.

Test Plan:
- Issue 0x0000000B (BITREV, id 3) with rs1 = 0x1; commit id 3, no kill, in the same cycle → next cycle out_valid_o=1, operator_o=BITREV, operand_a_o=0x1, operand_b_o=0, tag_o={3, rd}.
- Issue ROTLEFT id 1 then id 2, keep out_ready_i=1; commit id 1 with kill, then id 2 → only id 2 appears on out_valid_o, after one drop cycle.
- Issue id 4 and id 5 (Depth=2), no commits → third accepted issue sees issue_ready_o=0. Commit id 4 and handshake it out → issue_ready_o returns to 1 the cycle after the pop.
- Issue funct3=3 → issue_ready_o=1, issue_accept_o=0, queue unchanged.
- Issue ROTRIGHT with rs_valid=2'b01 → issue_ready_o=0 until rs_valid=2'b11.
- Committed entry with out_ready_i=0 for 3 cycles → outputs stable. Assert rst_i mid-hold → next cycle out_valid_o=0, queue empty.

Source files
------------

// File: rtl/xif_copro_pkg.sv
// rtl/xif_copro_pkg.sv - shared types and constants for the coprocessor issue/decode stage
package xif_copro_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int ID_WIDTH_DEF = 4;

    localparam logic [6:0] OPCODE_CUSTOM0  = 7'h0B;
    localparam logic [2:0] FUNCT3_BITREV   = 3'd0;
    localparam logic [2:0] FUNCT3_ROTLEFT  = 3'd1;
    localparam logic [2:0] FUNCT3_ROTRIGHT = 3'd2;

    typedef enum logic [1:0] {
        COPRO_NONE     = 2'd0,
        COPRO_BITREV   = 2'd1,
        COPRO_ROTLEFT  = 2'd2,
        COPRO_ROTRIGHT = 2'd3
    } copro_op_e;

    typedef struct packed {
        logic [ID_WIDTH_DEF-1:0] id;
        logic [4:0]              rd;
    } copro_tag_t;

    typedef struct packed {
        copro_op_e               op;
        logic [XLEN_DEF-1:0]     rs1;
        logic [XLEN_DEF-1:0]     rs2;
        logic [ID_WIDTH_DEF-1:0] id;
        logic [4:0]              rd;
        logic                    committed;
        logic                    killed;
    } copro_entry_t;

endpackage

// File: rtl/xif_copro_decoder.sv
// rtl/xif_copro_decoder.sv - combinational custom-0 decoder: accept, operator, required sources, rd
module xif_copro_decoder
    import xif_copro_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        accept_o,
    output copro_op_e   op_o,
    output logic [1:0]  rs_req_o,
    output logic [4:0]  rd_o
);

    always_comb begin
        accept_o = 1'b0;
        op_o     = COPRO_NONE;
        rs_req_o = 2'b00;
        rd_o     = instr_i[11:7];
        if (instr_i[6:0] == OPCODE_CUSTOM0 && instr_i[31:25] == 7'd0) begin
            case (instr_i[14:12])
                FUNCT3_BITREV: begin
                    accept_o = 1'b1;
                    op_o     = COPRO_BITREV;
                    rs_req_o = 2'b01;
                end
                FUNCT3_ROTLEFT: begin
                    accept_o = 1'b1;
                    op_o     = COPRO_ROTLEFT;
                    rs_req_o = 2'b11;
                end
                FUNCT3_ROTRIGHT: begin
                    accept_o = 1'b1;
                    op_o     = COPRO_ROTRIGHT;
                    rs_req_o = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/xif_copro_id_stage.sv
// rtl/xif_copro_id_stage.sv - CV-X-IF issue/decode stage with pending-commit queue; XIF_COPRO_ID_BYPASS_EN enables 0-cycle bypass
module xif_copro_id_stage
    import xif_copro_pkg::*;
#(
    parameter int  XLEN    = XLEN_DEF,
    parameter int  IdWidth = ID_WIDTH_DEF,
    parameter int  Depth   = 2,
    parameter type tag_t   = copro_tag_t
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    input  logic [1:0]         issue_rs_valid_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic [XLEN-1:0]    operand_a_o,
    output logic [XLEN-1:0]    operand_b_o,
    output copro_op_e          operator_o,
    output tag_t               tag_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    copro_entry_t    mem_q [Depth];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic            dec_accept;
    copro_op_e       dec_op;
    logic [1:0]      dec_rs_req;
    logic [4:0]      dec_rd;

    xif_copro_decoder u_decoder (
        .instr_i  (issue_instr_i),
        .accept_o (dec_accept),
        .op_o     (dec_op),
        .rs_req_o (dec_rs_req),
        .rd_o     (dec_rd)
    );

    logic full, rs_ok, enq, enq_wr, pop, bypass;
    logic new_commit, commit_hit;
    logic [PtrW-1:0] commit_idx, idx;
    copro_entry_t new_entry, head_entry, out_entry;
    logic head_valid, head_drop, head_out_valid;

    assign full              = (count_q == CntW'(Depth));
    assign rs_ok             = &(issue_rs_valid_i | ~dec_rs_req);
    assign issue_ready_o     = ~dec_accept | (~full & rs_ok);
    assign issue_accept_o    = dec_accept;
    assign issue_writeback_o = dec_accept;
    assign enq               = issue_valid_i & issue_ready_o & dec_accept;

    // Oldest valid, uncommitted entry with a matching id takes the commit.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        idx        = '0;
        for (int i = 0; i < Depth; i++) begin
            idx = head_q + PtrW'(i);
            if (!commit_hit && commit_valid_i && (CntW'(i) < count_q) &&
                !mem_q[idx].committed && mem_q[idx].id == commit_id_i) begin
                commit_hit = 1'b1;
                commit_idx = idx;
            end
        end
    end

    assign new_commit = commit_valid_i & ~commit_hit & (commit_id_i == issue_id_i);

    always_comb begin
        new_entry           = '0;
        new_entry.op        = dec_op;
        new_entry.rs1       = issue_rs1_i;
        new_entry.rs2       = (dec_op == COPRO_BITREV) ? '0 : issue_rs2_i;
        new_entry.id        = issue_id_i;
        new_entry.rd        = dec_rd;
        new_entry.committed = new_commit;
        new_entry.killed    = new_commit & commit_kill_i;
    end

`ifdef XIF_COPRO_ID_BYPASS_EN
    assign bypass = ~rst_i & (count_q == '0) & enq & new_entry.committed & ~new_entry.killed;
`else
    assign bypass = 1'b0;
`endif

    assign head_entry     = mem_q[head_q];
    assign head_valid     = (count_q != '0);
    assign head_drop      = head_valid & head_entry.killed;
    assign head_out_valid = head_valid & head_entry.committed & ~head_entry.killed;
    assign pop            = head_drop | (head_out_valid & out_ready_i);
    assign enq_wr         = enq & ~(bypass & out_ready_i);

    assign out_entry   = bypass ? new_entry : head_entry;
    assign out_valid_o = head_out_valid | bypass;
    assign operand_a_o = out_entry.rs1;
    assign operand_b_o = out_entry.rs2;
    assign operator_o  = out_entry.op;
    assign tag_o       = copro_tag_t'{id: out_entry.id, rd: out_entry.rd};

    assign head_d  = pop ? head_q + 1'b1 : head_q;
    assign tail_d  = enq_wr ? tail_q + 1'b1 : tail_q;
    assign count_d = count_q + CntW'(enq_wr) - CntW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (commit_hit) begin
                mem_q[commit_idx].committed <= 1'b1;
                mem_q[commit_idx].killed    <= commit_kill_i;
            end
            if (enq_wr) begin
                mem_q[tail_q] <= new_entry;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
